// File: rtl/pc_fetch_sequencer.sv
// PC fetch sequencer: selects the next PC each cycle and runs the instruction
// fetch handshake. It holds one returned word for decode, squashes responses
// made stale by a redirect, and halts on a misaligned redirect, a fetch
// timeout or a Halt request taken at an instruction boundary.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          MAX_WAIT     = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  output logic [31:0] Address,
  output logic        IMemReq,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr,
  output logic        InstrValid,
  input  logic        DecodeReady,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Halt,
  output logic        FetchFault,
  output logic [1:0]  State
);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    FETCH      = 2'd1,
    WAIT_DEC   = 2'd2,
    HALTED     = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [3:0]  wait_q, wait_d;
  logic        fault_q, fault_d;
  logic        halt_q, halt_d;

  logic        redir_now;
  logic [31:0] redir_tgt;
  logic        redir_bad;
  logic        halt_req;

  // Sequential PC increment; wraps modulo 2^32 without raising a fault.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // A jump outranks a branch raised in the same cycle.
  assign redir_now = JumpTaken | BranchTaken;
  assign redir_tgt = JumpTaken ? JumpTarget : BranchTarget;
  assign redir_bad = redir_now && (redir_tgt[1:0] != 2'b00);
  // A Halt seen earlier stays armed until the next instruction boundary.
  assign halt_req  = Halt | halt_q;

  assign State      = state_q;
  assign FetchFault = fault_q;

  // State, buffered word, pending redirect, wait counter, fault and halt flags.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= RESET_HOLD;
      instr_q    <= 32'h0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'h0;
      wait_q     <= 4'h0;
      fault_q    <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      wait_q     <= wait_d;
      fault_q    <= fault_d;
      halt_q     <= halt_d;
    end
  end

  // Next-state logic plus the combinational Address/handshake outputs.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    wait_d     = wait_q;
    fault_d    = fault_q;
    halt_d     = halt_q | Halt;
    Address    = PCResult;
    IMemReq    = 1'b0;
    InstrValid = 1'b0;
    Instr      = instr_q;

    unique case (state_q)
      RESET_HOLD: begin
        Address = RESET_VECTOR;
        wait_d  = 4'h0;
        pend_d  = 1'b0;
        state_d = FETCH;
      end

      FETCH: begin
        IMemReq = 1'b1;
        if (redir_bad) begin
          fault_d = 1'b1;
          state_d = HALTED;
        end else if (!IMemReady) begin
          // Still waiting: remember any redirect so the late word is dropped.
          wait_d = wait_q + 4'd1;
          if (redir_now) begin
            pend_d     = 1'b1;
            pend_tgt_d = redir_tgt;
          end
          if (wait_d == WAIT_LIMIT) begin
            fault_d = 1'b1;
            state_d = HALTED;
          end
        end else if (redir_now || pend_q) begin
          // Word is stale; a fresh redirect overrides the remembered one.
          Address = redir_now ? redir_tgt : pend_tgt_q;
          pend_d  = 1'b0;
          wait_d  = 4'h0;
          if (halt_req) state_d = HALTED;
        end else if (DecodeReady) begin
          Instr      = IMemData;
          InstrValid = 1'b1;
          Address    = pc_plus4(PCResult);
          wait_d     = 4'h0;
          if (halt_req) state_d = HALTED;
        end else begin
          instr_d = IMemData;
          wait_d  = 4'h0;
          state_d = WAIT_DEC;
        end
      end

      WAIT_DEC: begin
        InstrValid = 1'b1;
        if (redir_bad) begin
          fault_d = 1'b1;
          state_d = HALTED;
        end else if (redir_now) begin
          // Redirect beats a simultaneous accept; the buffered word is dropped.
          Address = redir_tgt;
          state_d = halt_req ? HALTED : FETCH;
        end else if (DecodeReady) begin
          Address = pc_plus4(PCResult);
          state_d = halt_req ? HALTED : FETCH;
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = HALTED;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: the stimulus thread drives one cycle
// of inputs and queues that cycle's expected outputs; a monitor on the falling
// edge pops each entry and compares the selected fields.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic [31:0] address;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        decode_ready = 1'b0;
  logic        jump_taken = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        halt = 1'b0;
  logic        fetch_fault;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  // Field-select mask bits for an expectation entry.
  localparam logic [5:0] M_ADDR = 6'h01;
  localparam logic [5:0] M_ST   = 6'h02;
  localparam logic [5:0] M_REQ  = 6'h04;
  localparam logic [5:0] M_VLD  = 6'h08;
  localparam logic [5:0] M_INS  = 6'h10;
  localparam logic [5:0] M_FLT  = 6'h20;
  localparam logic [5:0] M_ALL  = 6'h3F;
  localparam logic [5:0] M_CTL  = M_ADDR | M_ST | M_REQ | M_VLD | M_FLT;

  typedef struct {
    string       name;
    logic [5:0]  mask;
    logic [31:0] addr;
    logic [1:0]  st;
    logic        req;
    logic        vld;
    logic [31:0] ins;
    logic        flt;
  } exp_t;

  exp_t exp_q[$];

  pc_fetch_sequencer dut (
    .Clk          (clk),
    .Reset        (rst),
    .PCResult     (pc),
    .Address      (address),
    .IMemReq      (imem_req),
    .IMemReady    (imem_ready),
    .IMemData     (imem_data),
    .Instr        (instr),
    .InstrValid   (instr_valid),
    .DecodeReady  (decode_ready),
    .JumpTaken    (jump_taken),
    .JumpTarget   (jump_target),
    .BranchTaken  (branch_taken),
    .BranchTarget (branch_target),
    .Halt         (halt),
    .FetchFault   (fetch_fault),
    .State        (state)
  );

  always #5 clk = ~clk;

  // PC register model: loads Address on every rising edge.
  always @(posedge clk) pc <= address;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%h expected=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: compare the queued expectation for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.mask[0]) chk(e.name, "Address",    address,            e.addr);
      if (e.mask[1]) chk(e.name, "State",      32'(state),         32'(e.st));
      if (e.mask[2]) chk(e.name, "IMemReq",    32'(imem_req),      32'(e.req));
      if (e.mask[3]) chk(e.name, "InstrValid", 32'(instr_valid),   32'(e.vld));
      if (e.mask[4]) chk(e.name, "Instr",      instr,              e.ins);
      if (e.mask[5]) chk(e.name, "FetchFault", 32'(fetch_fault),   32'(e.flt));
    end
  end

  // Drive one cycle of inputs, queue its expectation, advance past the edge.
  task automatic cyc(input string nm, input logic rdy, input logic [31:0] dat, input logic dr,
                     input logic j, input logic [31:0] jtg, input logic b, input logic [31:0] btg,
                     input logic h, input logic [5:0] m, input logic [31:0] ea, input logic [1:0] es,
                     input logic erq, input logic ev, input logic [31:0] ei, input logic ef);
    exp_t e;
    imem_ready    = rdy;
    imem_data     = dat;
    decode_ready  = dr;
    jump_taken    = j;
    jump_target   = jtg;
    branch_taken  = b;
    branch_target = btg;
    halt          = h;
    e.name = nm; e.mask = m; e.addr = ea; e.st = es; e.req = erq; e.vld = ev; e.ins = ei; e.flt = ef;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Idle inputs, Reset pulsed for one cycle, then the RESET_HOLD cycle.
  task automatic reset_pulse(input string nm);
    rst = 1'b1;
    cyc({nm, "_rst"}, 0, 0, 0, 0, 0, 0, 0, 0, M_ALL, 32'h0, 2'd0, 0, 0, 32'h0, 0);
    rst = 1'b0;
    cyc({nm, "_hold"}, 0, 0, 0, 0, 0, 0, 0, 0, M_CTL, 32'h0, 2'd0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held three cycles, then straight-line fetch with decode always ready.
    for (int i = 0; i < 3; i++)
      cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0, M_ALL, 32'h0, 2'd0, 0, 0, 32'h0, 0);
    rst = 1'b0;
    cyc("hold",   1, 32'h1000_0000, 1, 0, 0, 0, 0, 0, M_CTL, 32'h0, 2'd0, 0, 0, 32'h0, 0);
    cyc("seq0",   1, 32'h1000_0000, 1, 0, 0, 0, 0, 0, M_ALL, 32'h4, 2'd1, 1, 1, 32'h1000_0000, 0);
    cyc("seq4",   1, 32'h1000_0004, 1, 0, 0, 0, 0, 0, M_ALL, 32'h8, 2'd1, 1, 1, 32'h1000_0004, 0);
    cyc("seq8",   1, 32'h1000_0008, 1, 0, 0, 0, 0, 0, M_ALL, 32'hC, 2'd1, 1, 1, 32'h1000_0008, 0);
    // Jump and branch together with a returning word: jump wins, word dropped.
    cyc("jmp",    1, 32'h1000_000C, 1, 1, 32'h40, 1, 32'h80, 0, M_CTL, 32'h40, 2'd1, 1, 0, 32'h0, 0);
    cyc("at40",   1, 32'h1000_0040, 1, 0, 0, 0, 0, 0, M_ALL, 32'h44, 2'd1, 1, 1, 32'h1000_0040, 0);
    // Branch during an outstanding fetch: late response squashed.
    cyc("brw0",   0, 32'h0, 1, 0, 0, 1, 32'h100, 0, M_CTL, 32'h44, 2'd1, 1, 0, 32'h0, 0);
    cyc("brw1",   0, 32'h0, 1, 0, 0, 0, 0, 0, M_CTL, 32'h44, 2'd1, 1, 0, 32'h0, 0);
    cyc("brw2",   0, 32'h0, 1, 0, 0, 0, 0, 0, M_CTL, 32'h44, 2'd1, 1, 0, 32'h0, 0);
    cyc("brdrop", 1, 32'h1000_0044, 1, 0, 0, 0, 0, 0, M_CTL, 32'h100, 2'd1, 1, 0, 32'h0, 0);
    cyc("at100",  1, 32'h1000_0100, 1, 0, 0, 0, 0, 0, M_ALL, 32'h104, 2'd1, 1, 1, 32'h1000_0100, 0);
    // Decode stall at PC 8, release, then misaligned branch target.
    cyc("jto8",   1, 32'h1000_0104, 1, 1, 32'h8, 0, 0, 0, M_CTL, 32'h8, 2'd1, 1, 0, 32'h0, 0);
    cyc("stall",  1, 32'h1000_0008, 0, 0, 0, 0, 0, 0, M_CTL, 32'h8, 2'd1, 1, 0, 32'h0, 0);
    cyc("wdec0",  0, 32'h0, 0, 0, 0, 0, 0, 0, M_ALL, 32'h8, 2'd2, 0, 1, 32'h1000_0008, 0);
    cyc("wdec1",  0, 32'h0, 0, 0, 0, 0, 0, 0, M_ALL, 32'h8, 2'd2, 0, 1, 32'h1000_0008, 0);
    cyc("wdacc",  0, 32'h0, 1, 0, 0, 0, 0, 0, M_ALL, 32'hC, 2'd2, 0, 1, 32'h1000_0008, 0);
    cyc("misal",  0, 32'h0, 1, 0, 0, 1, 32'h102, 0, M_CTL, 32'hC, 2'd1, 1, 0, 32'h0, 0);
    cyc("mfault", 0, 32'h0, 1, 0, 0, 0, 0, 0, M_CTL, 32'hC, 2'd3, 0, 0, 32'h0, 1);
    reset_pulse("clr1");
    // Fetch timeout: fifteen cycles without IMemReady.
    cyc("to1",    0, 32'h0, 1, 0, 0, 0, 0, 0, M_CTL, 32'h0, 2'd1, 1, 0, 32'h0, 0);
    for (int i = 2; i < 15; i++)
      cyc("tomid", 0, 32'h0, 1, 0, 0, 0, 0, 0, M_ST | M_FLT, 32'h0, 2'd1, 1, 0, 32'h0, 0);
    cyc("to15",   0, 32'h0, 1, 0, 0, 0, 0, 0, M_CTL, 32'h0, 2'd1, 1, 0, 32'h0, 0);
    cyc("tofault",0, 32'h0, 1, 0, 0, 0, 0, 0, M_CTL, 32'h0, 2'd3, 0, 0, 32'h0, 1);
    reset_pulse("clr2");
    // Halt pulse while waiting at 0x20 takes effect when the word is accepted.
    cyc("jto20",  1, 32'h1000_0000, 1, 1, 32'h20, 0, 0, 0, M_CTL, 32'h20, 2'd1, 1, 0, 32'h0, 0);
    cyc("hlt0",   0, 32'h0, 1, 0, 0, 0, 0, 1, M_CTL, 32'h20, 2'd1, 1, 0, 32'h0, 0);
    cyc("hlt1",   0, 32'h0, 1, 0, 0, 0, 0, 0, M_CTL, 32'h20, 2'd1, 1, 0, 32'h0, 0);
    cyc("hltacc", 1, 32'h1000_0020, 1, 0, 0, 0, 0, 0, M_ALL, 32'h24, 2'd1, 1, 1, 32'h1000_0020, 0);
    cyc("halted", 1, 32'h0, 1, 0, 0, 0, 0, 0, M_CTL, 32'h24, 2'd3, 0, 0, 32'h0, 0);
    cyc("hstay",  1, 32'h0, 1, 1, 32'h80, 0, 0, 0, M_CTL, 32'h24, 2'd3, 0, 0, 32'h0, 0);
    reset_pulse("clr3");
    // PC wrap at the top of the address space.
    cyc("jtop",   1, 32'h1000_0000, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, M_CTL, 32'hFFFF_FFFC, 2'd1, 1, 0, 32'h0, 0);
    cyc("wrap",   1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0, M_ALL, 32'h0, 2'd1, 1, 1, 32'hDEAD_BEEF, 0);
    // Buffered word with simultaneous accept and redirect: redirect wins.
    cyc("buf",    1, 32'hCAFE_0000, 0, 0, 0, 0, 0, 0, M_CTL, 32'h0, 2'd1, 1, 0, 32'h0, 0);
    cyc("wdred",  0, 32'h0, 1, 1, 32'h200, 0, 0, 0, M_ALL, 32'h200, 2'd2, 0, 1, 32'hCAFE_0000, 0);
    cyc("at200",  0, 32'h0, 1, 0, 0, 0, 0, 0, M_CTL, 32'h200, 2'd1, 1, 0, 32'h0, 0);
    // Every queued expectation must have been consumed by the monitor.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Controls the 32-bit program counter register and the instruction-memory fetch handshake.
- Each cycle it drives the PC register's Address input: hold current PC, PC+4, reset vector, or redirect target.
- Issues fetch requests, buffers one returned instruction for decode, and handles branch/jump redirects with squash.
- Halts on a fetch fault, a memory timeout, or an explicit halt request.

Parameters:
- RESET_VECTOR, 32'h00000000, first fetch address loaded after reset.
- MAX_WAIT, 15, consecutive FETCH cycles without IMemReady before timeout fault (4-bit counter).

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- PCResult  input  32  current PC from the PC register output.
- Address  output  32  next PC, driven to the PC register input (the register loads every cycle).
- IMemReq  output  1  fetch request for address PCResult.
- IMemReady  input  1  instruction word valid on IMemData this cycle.
- IMemData  input  32  instruction word from memory.
- Instr  output  32  instruction presented to decode.
- InstrValid  output  1  Instr valid.
- DecodeReady  input  1  decode accepts Instr this cycle.
- JumpTaken  input  1  jump redirect request.
- JumpTarget  input  32  jump target.
- BranchTaken  input  1  branch redirect request.
- BranchTarget  input  32  branch target.
- Halt  input  1  stop fetching at the next instruction boundary.
- FetchFault  output  1  sticky fault flag.
- State  output  2  FSM state: 0 RESET_HOLD, 1 FETCH, 2 WAIT_DEC, 3 HALTED.

Behaviour:
- Reset (async, immediate) values:
  - State=RESET_HOLD, IMemReq=0, InstrValid=0, Instr=0, FetchFault=0.
  - Pending-redirect flag and target = 0; wait counter = 0.
  - Address=RESET_VECTOR for as long as the FSM is in RESET_HOLD.
- RESET_HOLD:
  - Held while Reset is high, then for one further cycle after deassertion.
  - Address=RESET_VECTOR, so the PC register loads it; next state FETCH.
- Redirect selection: JumpTaken has priority over BranchTaken. The effective target is the selected one.
- Misaligned target (target[1:0]!=0) at any redirect: FetchFault=1, Address=PCResult, go to HALTED.
- FETCH state: IMemReq=1, InstrValid=0.
  - IMemReady=0: Address=PCResult and wait counter +1.
    - A redirect this cycle latches its target into the pending register; the later response is discarded.
    - When the counter reaches MAX_WAIT: FetchFault=1, go to HALTED.
  - IMemReady=1 with a pending redirect or a redirect this cycle: discard the word. A same-cycle redirect wins over the pending one. Address=target, clear pending, clear counter, stay in FETCH.
  - IMemReady=1, no redirect, DecodeReady=1: pass the word through. Instr=IMemData and InstrValid=1 in the same cycle. Address=PCResult+4, stay in FETCH.
  - IMemReady=1, no redirect, DecodeReady=0: latch the word into Instr, Address=PCResult, go to WAIT_DEC.
- WAIT_DEC state: IMemReq=0, InstrValid=1, Instr=latched word, Address=PCResult.
  - DecodeReady=1: Address=PCResult+4, go to FETCH.
  - A redirect discards the buffered word (InstrValid=0 from the next cycle), Address=target, go to FETCH.
  - When redirect and DecodeReady are both high, the redirect wins and the word is not consumed.
- Halt is honoured only at a boundary: when a word is accepted by decode, or when a redirect is applied.
  - At that boundary Address is still updated (PC+4 or target), then go to HALTED.
  - Halt arriving during an outstanding request waits for that boundary.
- HALTED: IMemReq=0, InstrValid=0, Address=PCResult. Leaves only via Reset. FetchFault holds its value.
- Arithmetic: PC+4 is unsigned modulo 2^32 (32'hFFFFFFFC+4 = 32'h00000000, no fault).
- Reset asserted mid-fetch: the outstanding response is abandoned and the pending redirect is cleared.

Test Plan:
- Reset high for 3 cycles, then low; IMemReady=1 every cycle and DecodeReady=1 → Address sequence 0,0,4,8,C; InstrValid=1 from the first FETCH cycle onward.
- IMemReady held 0 for 15 cycles in FETCH → FetchFault=1 on cycle 15, State=3, IMemReq=0. Reset then clears FetchFault to 0.
- JumpTaken with JumpTarget=0x40 and BranchTaken with BranchTarget=0x80, same cycle as IMemReady → word discarded, InstrValid=0, Address=0x40. The next fetch delivers the word at 0x40.
- BranchTaken with BranchTarget=0x100 while IMemReady=0; response arrives 3 cycles later → that response is dropped, Address=0x100, fetch restarts at 0x100.
- DecodeReady=0 when the word arrives at PC=0x8 → State=2, Instr holds the word, Address=8. DecodeReady=1 two cycles later → Address=0xC. BranchTarget=0x102 → FetchFault=1, HALTED.
- Halt asserted while waiting at PCResult=0x20 → after the word is accepted Address=0x24, State=3. PC=0xFFFFFFFC accepted → Address=0x00000000.
